// File: rtl/time_set_entry_pkg.sv
// Shared types, constants and helpers for the time_set_entry block.
package time_set_entry_pkg;

  // Field selector as presented on field_sel.
  typedef enum logic [1:0] {
    FieldNone = 2'd0,
    FieldHr   = 2'd1,
    FieldMin  = 2'd2,
    FieldSec  = 2'd3
  } field_e;

  // Edit state machine states.
  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StEditHr  = 2'd1,
    StEditMin = 2'd2,
    StEditSec = 2'd3
  } state_e;

  localparam logic [5:0] HR_MAX     = 6'd23;
  localparam logic [5:0] MS_MAX     = 6'd59;
  localparam logic [3:0] SEP_NIBBLE = 4'hF;

  // Increment with wrap to 0 past max.
  function automatic logic [5:0] wrap_inc(input logic [5:0] val, input logic [5:0] max);
    return (val >= max) ? 6'd0 : val + 6'd1;
  endfunction

  // Decrement with wrap from 0 to max.
  function automatic logic [5:0] wrap_dec(input logic [5:0] val, input logic [5:0] max);
    return (val == 6'd0) ? max : val - 6'd1;
  endfunction

  // Two BCD digits {tens, ones}; out-of-range values are converted as-is.
  function automatic logic [7:0] to_bcd(input logic [5:0] val);
    return {4'(val / 6'd10), 4'(val % 6'd10)};
  endfunction

endpackage

// File: rtl/time_set_entry_button_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, one-cycle
// registered press pulse on each accepted rising level.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            level_prev_q;
  logic            press_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Synchronize the asynchronous button into the clock domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Count while synced input disagrees; flip accepted level once the count is reached.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(DEBOUNCE_CYCLES)) begin
      level_d = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Accepted level, counter and rising-edge press pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q      <= 1'b0;
      cnt_q        <= '0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      level_q      <= level_d;
      cnt_q        <= cnt_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/time_set_entry.sv
// Button-driven hour/minute/second entry feeding the clock counter and display.
// Optional macro TIME_SET_BLINK_EN: blink the selected field while editing.
module time_set_entry
  import time_set_entry_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned BLINK_CYCLES    = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_ok,
  input  logic [4:0]  cur_hr,
  input  logic [5:0]  cur_min,
  input  logic [5:0]  cur_sec,
  output logic        editing,
  output logic [1:0]  field_sel,
  output logic [4:0]  set_hr,
  output logic [5:0]  set_min,
  output logic [5:0]  set_sec,
  output logic        set_valid,
  output logic [31:0] time_data
);

  if (BLINK_CYCLES == 0) begin : g_blink_cfg_err
    $error("BLINK_CYCLES must be nonzero");
  end

  logic p_mode, p_up, p_down, p_ok;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_mode (
    .clk(clk), .rst(rst), .btn_raw(btn_mode), .press(p_mode)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst(rst), .btn_raw(btn_up), .press(p_up)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst(rst), .btn_raw(btn_down), .press(p_down)
  );
  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ok (
    .clk(clk), .rst(rst), .btn_raw(btn_ok), .press(p_ok)
  );

  state_e      state_q, state_d;
  logic [4:0]  hr_q, hr_d;
  logic [5:0]  min_q, min_d, sec_q, sec_d;
  logic [4:0]  set_hr_q, set_hr_d;
  logic [5:0]  set_min_q, set_min_d, set_sec_q, set_sec_d;
  logic        set_valid_q, set_valid_d;
  logic [31:0] time_data_q, time_data_d;
  logic        field_chg;
  logic        blink_phase;
  field_e      field;

  // Next state, edit arithmetic and commit; priority ok > mode > up/down.
  always_comb begin
    state_d     = state_q;
    hr_d        = hr_q;
    min_d       = min_q;
    sec_d       = sec_q;
    set_hr_d    = set_hr_q;
    set_min_d   = set_min_q;
    set_sec_d   = set_sec_q;
    set_valid_d = 1'b0;
    field_chg   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (p_mode) begin
          hr_d      = cur_hr;
          min_d     = cur_min;
          sec_d     = cur_sec;
          state_d   = StEditHr;
          field_chg = 1'b1;
        end
      end
      default: begin
        if (p_ok) begin
          set_hr_d    = hr_q;
          set_min_d   = min_q;
          set_sec_d   = sec_q;
          set_valid_d = 1'b1;
          state_d     = StIdle;
        end else if (p_mode) begin
          field_chg = 1'b1;
          case (state_q)
            StEditHr:  state_d = StEditMin;
            StEditMin: state_d = StEditSec;
            default:   state_d = StEditHr;
          endcase
        end else if (p_up ^ p_down) begin
          // Simultaneous up and down cancel out.
          field_chg = 1'b1;
          case (state_q)
            StEditHr: hr_d = p_up ? 5'(wrap_inc({1'b0, hr_q}, HR_MAX))
                                  : 5'(wrap_dec({1'b0, hr_q}, HR_MAX));
            StEditMin: min_d = p_up ? wrap_inc(min_q, MS_MAX) : wrap_dec(min_q, MS_MAX);
            default:   sec_d = p_up ? wrap_inc(sec_q, MS_MAX) : wrap_dec(sec_q, MS_MAX);
          endcase
        end
      end
    endcase
  end

  // State, edit and commit registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      hr_q        <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      set_hr_q    <= '0;
      set_min_q   <= '0;
      set_sec_q   <= '0;
      set_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hr_q        <= hr_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      set_hr_q    <= set_hr_d;
      set_min_q   <= set_min_d;
      set_sec_q   <= set_sec_d;
      set_valid_q <= set_valid_d;
    end
  end

`ifdef TIME_SET_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_phase_q;

  // Free-running blink phase; restarted on every edit so the field shows solid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (field_chg) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BlinkW'(BLINK_CYCLES - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + BlinkW'(1);
    end
  end

  assign blink_phase = blink_phase_q;
`else
  // Blink disabled: the selected field is always shown.
  assign blink_phase = 1'b0;
`endif

  // Field selector decoded from state.
  always_comb begin
    field = FieldNone;
    unique case (state_q)
      StIdle:    field = FieldNone;
      StEditHr:  field = FieldHr;
      StEditMin: field = FieldMin;
      StEditSec: field = FieldSec;
    endcase
  end

  // Display word: live time in IDLE, edit registers otherwise, blanked field when blinking.
  always_comb begin
    logic [7:0] hr_bcd, min_bcd, sec_bcd;
    if (state_q == StIdle) begin
      hr_bcd  = to_bcd({1'b0, cur_hr});
      min_bcd = to_bcd(cur_min);
      sec_bcd = to_bcd(cur_sec);
    end else begin
      hr_bcd  = to_bcd({1'b0, hr_q});
      min_bcd = to_bcd(min_q);
      sec_bcd = to_bcd(sec_q);
    end
    if (blink_phase) begin
      case (state_q)
        StEditHr:  hr_bcd  = {SEP_NIBBLE, SEP_NIBBLE};
        StEditMin: min_bcd = {SEP_NIBBLE, SEP_NIBBLE};
        StEditSec: sec_bcd = {SEP_NIBBLE, SEP_NIBBLE};
        default:   ;
      endcase
    end
    time_data_d = {hr_bcd, SEP_NIBBLE, min_bcd, SEP_NIBBLE, sec_bcd};
  end

  // Registered display word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_data_q <= 32'h00F0_0F00;
    end else begin
      time_data_q <= time_data_d;
    end
  end

  assign editing   = (state_q != StIdle);
  assign field_sel = field;
  assign set_hr    = set_hr_q;
  assign set_min   = set_min_q;
  assign set_sec   = set_sec_q;
  assign set_valid = set_valid_q;
  assign time_data = time_data_q;

endmodule
